// File: rtl/key_debounce_multi.sv
// key_debounce_multi
//
// Multi-channel push-button conditioner. Every channel is independent and
// consists of a 2-FF synchroniser, a polarity normaliser, a consecutive-sample
// debounce filter and a small hold FSM that produces press, release,
// long-press and auto-repeat pulses.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high
//   keys_in       raw asynchronous key pins (N_KEYS)
//   pressed       debounced level, 1 = pressed (registered)
//   press_pulse   1-cycle pulse on accepted press
//   release_pulse 1-cycle pulse on accepted release
//   long_pulse    1-cycle pulse LONG_CYCLES after press_pulse
//   repeat_pulse  1-cycle pulse every REPEAT_CYCLES after long_pulse
//   dbg_state     per-channel FSM state, 2 bits per key
//                 (2'b00 idle, 2'b01 held, 2'b10 repeat)
//
// There are no handshakes: every output is a free-running registered level
// or single-cycle pulse that the consumer samples on clk.

module key_debounce_multi #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_KEYS-1:0]     keys_in,
  output logic [N_KEYS-1:0]     pressed,
  output logic [N_KEYS-1:0]     press_pulse,
  output logic [N_KEYS-1:0]     release_pulse,
  output logic [N_KEYS-1:0]     long_pulse,
  output logic [N_KEYS-1:0]     repeat_pulse,
  output logic [2*N_KEYS-1:0]   dbg_state
);

  localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW     = $clog2(LONG_CYCLES + 1);
  localparam int RW_RAW = $clog2(REPEAT_CYCLES + 1);
  localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;
  // One hold counter serves both the long-press and the repeat interval.
  localparam int HW     = (LW > RW) ? LW : RW;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  // Pin level of a released key; also the synchroniser reset value.
  localparam logic          PIN_IDLE  = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic          r_sync0;
    logic          r_sync1;
    logic          r_stable;
    logic          r_stable_prev;
    logic [DW-1:0] r_db_cnt;
    logic          r_press;
    logic          r_release;
    logic          w_lvl;
    logic          w_db_done;
    logic          w_fall;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_nxt;
    logic          r_long;
    logic          r_repeat;
    logic          w_long_nxt;
    logic          w_repeat_nxt;

    assign w_lvl     = r_sync1 ^ PIN_IDLE;
    // Last of the required consecutive differing samples: stable flips now.
    assign w_db_done = (w_lvl != r_stable) && (r_db_cnt == DB_LAST);
    // A release being accepted on this edge; lets the FSM suppress a
    // long/repeat pulse whose threshold lands on the same edge.
    assign w_fall    = w_db_done && r_stable;

    // Synchroniser, debounce filter and press/release edge detect.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_sync0       <= PIN_IDLE;
        r_sync1       <= PIN_IDLE;
        r_stable      <= 1'b0;
        r_stable_prev <= 1'b0;
        r_db_cnt      <= '0;
        r_press       <= 1'b0;
        r_release     <= 1'b0;
      end else begin
        r_sync0       <= keys_in[g];
        r_sync1       <= r_sync0;
        r_stable_prev <= r_stable;
        r_press       <= r_stable & ~r_stable_prev;
        r_release     <= ~r_stable & r_stable_prev;
        if (w_lvl != r_stable) begin
          if (w_db_done) begin
            r_stable <= w_lvl;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end else begin
          // Agreement with the accepted level restarts the count.
          r_db_cnt <= '0;
        end
      end
    end

    // Hold FSM state register.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_state    <= S_IDLE;
        r_hold_cnt <= '0;
        r_long     <= 1'b0;
        r_repeat   <= 1'b0;
      end else begin
        r_state    <= w_state_nxt;
        r_hold_cnt <= w_hold_nxt;
        r_long     <= w_long_nxt;
        r_repeat   <= w_repeat_nxt;
      end
    end

    // Hold FSM next state. The FSM enters HELD on the same edge that
    // registers press_pulse, so counting to LONG_CYCLES-1 there places
    // long_pulse exactly LONG_CYCLES cycles after press_pulse.
    always_comb begin
      w_state_nxt  = r_state;
      w_hold_nxt   = r_hold_cnt;
      w_long_nxt   = 1'b0;
      w_repeat_nxt = 1'b0;
      if (!r_stable || w_fall) begin
        w_state_nxt = S_IDLE;
        w_hold_nxt  = '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            w_state_nxt = S_HELD;
            w_hold_nxt  = '0;
          end
          S_HELD: begin
            if (r_hold_cnt == LONG_LAST) begin
              w_long_nxt  = 1'b1;
              w_state_nxt = S_REPEAT;
              w_hold_nxt  = '0;
            end else begin
              w_hold_nxt = r_hold_cnt + 1'b1;
            end
          end
          S_REPEAT: begin
            // With REPEAT_CYCLES = 0 the channel parks here silently.
            if (REPEAT_CYCLES != 0) begin
              if (r_hold_cnt == REP_LAST) begin
                w_repeat_nxt = 1'b1;
                w_hold_nxt   = '0;
              end else begin
                w_hold_nxt = r_hold_cnt + 1'b1;
              end
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_hold_nxt  = '0;
          end
        endcase
      end
    end

    assign pressed[g]            = r_stable;
    assign press_pulse[g]        = r_press;
    assign release_pulse[g]      = r_release;
    assign long_pulse[g]         = r_long;
    assign repeat_pulse[g]       = r_repeat;
    assign dbg_state[2*g +: 2]   = r_state;
  end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Testbench for key_debounce_multi with DEBOUNCE_CYCLES=4, LONG_CYCLES=20,
// REPEAT_CYCLES=8, active-low pins. Directed scenarios followed by random
// key activity; every cycle is compared against a behavioural model that
// derives long/repeat pulses from the distance to the press edge.

module tb_key_debounce_multi;
  localparam int NK   = 4;
  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int RPT  = 8;

  logic            clk;
  logic            reset;
  logic [NK-1:0]   keys_in;
  logic [NK-1:0]   pressed;
  logic [NK-1:0]   press_pulse;
  logic [NK-1:0]   release_pulse;
  logic [NK-1:0]   long_pulse;
  logic [NK-1:0]   repeat_pulse;
  logic [2*NK-1:0] dbg_state;

  key_debounce_multi #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LONG),
    .REPEAT_CYCLES(RPT), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .keys_in(keys_in),
    .pressed(pressed), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and observation ----------------
  int checks   = 0;
  int failures = 0;
  int n        = 0;   // edge index

  int press_cnt[NK], rel_cnt[NK], long_cnt[NK], rep_cnt[NK];
  int press_n[NK], long_n[NK], rise_n[NK];
  logic [NK-1:0] last_pressed;
  int rep_q[$];                     // key1 repeat offsets from its press
  logic [15:0] exp_q[$];            // expected key1 repeat offsets

  // ---------------- reference model ----------------
  bit m_s0[NK], m_s1[NK], m_stable[NK], m_prev[NK];
  int m_run[NK], m_pedge[NK];
  logic [NK-1:0] e_pressed, e_press, e_rel, e_long, e_rep;

  task automatic model_edge();
    for (int k = 0; k < NK; k++) begin
      if (reset) begin
        m_s0[k] = 1'b1; m_s1[k] = 1'b1;
        m_stable[k] = 1'b0; m_prev[k] = 1'b0;
        m_run[k] = 0; m_pedge[k] = -1;
        e_press[k] = 1'b0; e_rel[k] = 1'b0;
        e_long[k] = 1'b0; e_rep[k] = 1'b0;
      end else begin
        bit lvl;
        bit nst;
        int d;
        lvl = (m_s1[k] == 1'b0);
        nst = m_stable[k];
        if (lvl != m_stable[k]) begin
          m_run[k]++;
          if (m_run[k] == DB) begin
            nst = lvl;
            m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
        e_press[k] = m_stable[k] && !m_prev[k];
        e_rel[k]   = !m_stable[k] && m_prev[k];
        if (e_press[k] && nst) m_pedge[k] = n;
        if (!nst) m_pedge[k] = -1;
        e_long[k] = 1'b0;
        e_rep[k]  = 1'b0;
        if (m_pedge[k] >= 0) begin
          d = n - m_pedge[k];
          e_long[k] = (d == LONG);
          e_rep[k]  = (RPT > 0) && (d > LONG) && ((d - LONG) % RPT == 0);
        end
        m_prev[k]   = m_stable[k];
        m_stable[k] = nst;
        m_s1[k]     = m_s0[k];
        m_s0[k]     = keys_in[k];
      end
      e_pressed[k] = m_stable[k];
    end
  endtask

  // ---------------- check helpers ----------------
  task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, n, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("pressed", pressed, e_pressed);
    chk("press_pulse", press_pulse, e_press);
    chk("release_pulse", release_pulse, e_rel);
    chk("long_pulse", long_pulse, e_long);
    chk("repeat_pulse", repeat_pulse, e_rep);
    for (int k = 0; k < NK; k++) begin
      if (press_pulse[k] === 1'b1) begin press_cnt[k]++; press_n[k] = n; end
      if (release_pulse[k] === 1'b1) rel_cnt[k]++;
      if (long_pulse[k] === 1'b1) begin long_cnt[k]++; long_n[k] = n; end
      if (repeat_pulse[k] === 1'b1) begin
        rep_cnt[k]++;
        if (k == 1) rep_q.push_back(n - press_n[1]);
      end
      if (pressed[k] === 1'b1 && last_pressed[k] !== 1'b1) rise_n[k] = n;
      last_pressed[k] = pressed[k];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    n++;
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic wait_press(input int k, input int budget);
    int c0;
    c0 = press_cnt[k];
    for (int i = 0; i < budget && press_cnt[k] == c0; i++) step();
    chk_int("press_wait", press_cnt[k] - c0, 1);
  endtask

  task automatic check_repeats(input string tag);
    exp_q.delete();
    for (int j = 1; j <= 5; j++) exp_q.push_back(16'(LONG + j * RPT));
    chk_int({tag, "_count"}, rep_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rep_q.size() > 0) begin
      chk_int({tag, "_offset"}, rep_q.pop_front(), int'(exp_q.pop_front()));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    int p;
    int tot;
    logic [NK-1:0] saved;
    logic [NK-1:0] pp;

    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0; rep_cnt[k] = 0;
      press_n[k] = 0; long_n[k] = 0; rise_n[k] = 0;
      m_s0[k] = 1'b1; m_s1[k] = 1'b1; m_stable[k] = 1'b0; m_prev[k] = 1'b0;
      m_run[k] = 0; m_pedge[k] = -1;
    end
    last_pressed = '0;

    // Reset with keys released, then idle.
    reset = 1'b1;
    keys_in = 4'hF;
    repeat (3) step();
    checks++;
    assert (dbg_state === 8'h00) else begin
      failures++;
      $error("FAIL reset_state edge=%0d observed=%h expected=00", n, dbg_state);
    end
    reset = 1'b0;
    repeat (30) step();
    tot = 0;
    for (int k = 0; k < NK; k++) tot += press_cnt[k] + rel_cnt[k] + long_cnt[k] + rep_cnt[k];
    chk_int("idle_quiet", tot, 0);

    // Bounce on key0: 3 low, 1 high, then steady low.
    keys_in[0] = 1'b0;
    repeat (3) step();
    keys_in[0] = 1'b1;
    step();
    keys_in[0] = 1'b0;
    e0 = n + 1;
    repeat (12) step();
    chk_int("bounce_press_count", press_cnt[0], 1);
    chk_int("bounce_press_edge", press_n[0], e0 + 6);
    chk_int("bounce_pressed_edge", rise_n[0], e0 + 5);
    keys_in[0] = 1'b1;
    repeat (12) step();
    chk_int("key0_release_count", rel_cnt[0], 1);

    // Long hold on key1 with repeats.
    keys_in[1] = 1'b0;
    wait_press(1, 20);
    p = press_n[1];
    rep_q.delete();
    while (n < p + 60) step();
    chk_int("long_offset", long_n[1] - p, LONG);
    chk_int("long_count", long_cnt[1], 1);
    check_repeats("repeat");
    keys_in[1] = 1'b1;
    repeat (20) step();
    chk_int("key1_release_count", rel_cnt[1], 1);
    chk_int("no_repeat_after_release", rep_cnt[1], 5);

    // Keys 2 and 3 on the same edge.
    keys_in = 4'b0011;
    pp = '0;
    for (int i = 0; i < 20 && pp == '0; i++) begin
      step();
      pp = press_pulse;
    end
    chk("dual_press", pp, 4'b1100);
    repeat (5) step();
    keys_in = 4'hF;
    repeat (15) step();

    // Release glitch on key1 while repeating.
    keys_in[1] = 1'b0;
    wait_press(1, 20);
    p = press_n[1];
    rep_q.delete();
    while (n < p + 30) step();
    keys_in[1] = 1'b1;
    repeat (3) step();
    keys_in[1] = 1'b0;
    while (n < p + 60) step();
    check_repeats("glitch_repeat");
    chk_int("glitch_no_release", rel_cnt[1], 1);

    // Reset mid-repeat with key1 still held.
    reset = 1'b1;
    step();
    chk("reset_pressed", pressed, 4'h0);
    chk("reset_pulses", press_pulse | release_pulse | long_pulse | repeat_pulse, 4'h0);
    step();
    reset = 1'b0;
    e0 = n + 1;
    wait_press(1, 20);
    chk_int("post_reset_press_edge", press_n[1], e0 + 6);
    p = press_n[1];
    while (n < p + 22) step();
    chk_int("post_reset_long_offset", long_n[1] - p, LONG);
    keys_in = 4'hF;
    repeat (15) step();

    // Random activity, glitches and occasional reset.
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        saved = keys_in;
        keys_in = keys_in ^ 4'($urandom_range(1, 15));
        repeat ($urandom_range(1, 3)) step();
        keys_in = saved;
      end else if (r == 1) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 2)) step();
        reset = 1'b0;
      end else begin
        keys_in = 4'($urandom_range(0, 15));
        repeat ($urandom_range(1, 45)) step();
      end
    end
    keys_in = 4'hF;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
